// File: rtl/phase_sequencer_pkg.sv
// Shared constants for the instruction phase sequencer: state encoding,
// phase indices used by the control decoder, and debounce defaults.
package phase_sequencer_pkg;

  localparam int STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_P1      = 4'd1;
  localparam logic [3:0] S_P2      = 4'd2;
  localparam logic [3:0] S_P3      = 4'd3;
  localparam logic [3:0] S_WAIT_IN = 4'd4;
  localparam logic [3:0] S_P34     = 4'd5;
  localparam logic [3:0] S_P4      = 4'd6;
  localparam logic [3:0] S_P5      = 4'd7;
  localparam logic [3:0] S_HALTED  = 4'd8;

  localparam int DEBOUNCE_LEN_DEFAULT = 16;

  localparam int NUM_PHASES = 6;
  localparam int PH_P1   = 0;
  localparam int PH_P2   = 1;
  localparam int PH_P3   = 2;
  localparam int PH_P34  = 3;
  localparam int PH_P4   = 4;
  localparam int PH_P5   = 5;

  // Phase strobe vector for a given state; non-phase states give all zeros.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input state_t st);
    logic [NUM_PHASES-1:0] oh;
    oh = '0;
    case (st)
      S_P1:    oh[PH_P1]  = 1'b1;
      S_P2:    oh[PH_P2]  = 1'b1;
      S_P3:    oh[PH_P3]  = 1'b1;
      S_P34:   oh[PH_P34] = 1'b1;
      S_P4:    oh[PH_P4]  = 1'b1;
      S_P5:    oh[PH_P5]  = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/phase_sequencer_step_debouncer.sv
// Synchronizes and debounces the raw step button; emits a one-cycle pulse
// when the accepted level rises.
module step_debouncer
  import phase_sequencer_pkg::*;
#(
  parameter int LEN = DEBOUNCE_LEN_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic step_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(LEN + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles that disagree with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(LEN - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= step_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase ring with run/step gating, IN stall, HALT parking and a
// retired-instruction counter for the debug display.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEBOUNCE_LEN_DEFAULT,
  parameter int COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_en_i,
  input  logic               step_i,
  input  logic               halt_req_i,
  input  logic               io_wait_i,
  input  logic               in_valid_i,
  output logic               in_ack_o,
  output logic               p1_o,
  output logic               p2_o,
  output logic               p3_o,
  output logic               p3to4_o,
  output logic               p4_o,
  output logic               p5_o,
  output logic               halted_o,
  output logic               stalled_o,
  output logic [COUNT_W-1:0] instr_count_o
);

  state_t                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic [NUM_PHASES-1:0]   phase_q;
  logic                    halted_q, stalled_q;
  logic                    step_rise_s;

  step_debouncer #(.LEN(DEBOUNCE_LEN)) u_step_debouncer (
    .clock  (clock),
    .reset  (reset),
    .step_i (step_i),
    .rise_o (step_rise_s)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run_en_i || pending_q) state_d = S_P1; else state_d = S_IDLE;
      S_P1:      state_d = S_P2;
      S_P2:      state_d = S_P3;
      S_P3:      if (io_wait_i) state_d = S_WAIT_IN; else state_d = S_P34;
      S_WAIT_IN: if (in_valid_i) state_d = S_P34; else state_d = S_WAIT_IN;
      S_P34:     state_d = S_P4;
      S_P4:      state_d = S_P5;
      S_P5: begin
        if (halt_req_i)    state_d = S_HALTED;
        else if (run_en_i) state_d = S_P1;
        else               state_d = S_IDLE;
      end
      S_HALTED:  if (!run_en_i) state_d = S_IDLE; else state_d = S_HALTED;
      default:   state_d = S_IDLE;
    endcase
  end

  // Step edges only count while idle and not free-running; leaving IDLE consumes them.
  always_comb begin
    pending_d = pending_q;
    if ((state_q == S_IDLE) && (run_en_i || pending_q)) begin
      pending_d = 1'b0;
    end else if (step_rise_s && (state_q == S_IDLE) && !run_en_i) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_comb begin
    count_d = count_q;
    if (state_q == S_P5) begin
      count_d = count_q + COUNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      count_q   <= '0;
      phase_q   <= '0;
      halted_q  <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      phase_q   <= phase_onehot(state_d);
      halted_q  <= (state_d == S_HALTED);
      stalled_q <= (state_d == S_WAIT_IN);
    end
  end

  assign in_ack_o      = (state_q == S_WAIT_IN) && in_valid_i;
  assign p1_o          = phase_q[PH_P1];
  assign p2_o          = phase_q[PH_P2];
  assign p3_o          = phase_q[PH_P3];
  assign p3to4_o       = phase_q[PH_P34];
  assign p4_o          = phase_q[PH_P4];
  assign p5_o          = phase_q[PH_P5];
  assign halted_o      = halted_q;
  assign stalled_o     = stalled_q;
  assign instr_count_o = count_q;

endmodule
